riscv_multicycle_ctrl: RTL and testbench

Control FSM that sequences the 64-bit RISC-V datapath as a multi-cycle machine. It drives the PC, instruction-register, register-file and data-memory enables, and the datapath mux selects. It waits on a data-memory ready handshake and retires one instruction at a time. It sits between the decoder opcode field and the existing datapath enables, and replaces the fixed single-cycle enable timing.

---
 rtl/riscv_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle control FSM sequencing the 64-bit RISC-V datapath.
// Define RISCV_CTRL_PERF_EN to build the active-cycle and memory-stall counters.
module riscv_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic             pc_src,
  output logic             alu_src_sel,
  output logic             reg_write_en,
  output logic             mem_req,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         WAIT_W    = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  state_t             boundary;
  logic [6:0]         op_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               err_set;
  logic               op_legal;
  logic               is_i, is_load, is_store, is_branch;
  logic               timeout;

  // Classification uses the live opcode in DECODE, the latched copy everywhere after.
  assign op_legal  = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  assign is_i      = (op_q == OP_I);
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign timeout   = !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign boundary  = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d      = state_q;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = 1'b0;
    alu_src_sel  = 1'b0;
    reg_write_en = 1'b0;
    mem_req      = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    wb_sel       = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_write_en = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_sel = is_i | is_load | is_store;
        if (is_branch) begin
          pc_write_en = 1'b1;
          pc_src      = branch_cond;
          state_d     = boundary;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_read_en  = is_load;
        mem_write_en = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write_en = 1'b1;
            state_d     = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        wb_sel       = is_load;
        pc_write_en  = 1'b1;
        state_d      = boundary;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      error     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      // Wait counter is zero on every MEM entry and counts cycles spent in MEM.
      wait_q  <= (state_q == S_MEM) ? wait_q + WAIT_W'(1) : '0;
      if (err_set) error <= 1'b1;
      if (pc_write_en) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign busy        = !(state_q inside {S_IDLE, S_HALT});
  assign retired_cnt = retired_q;

`ifdef RISCV_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (busy) cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_MEM && !mem_ready) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: instruction table, directed corner
// sequences and a randomized instruction stream against a per-instruction trace model.
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 16;
`ifdef RISCV_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0] st;
    logic ir, pcw, pcs, alu, rw, mreq, mrd, mwr, wbs, busy, err;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    int         delay;
    logic       bc;
    int         lat;
    int         mem_cyc;
    logic [5:0] seen;   // {alu_src_sel, wb_sel, pc_src, reg_write_en, mem_read_en, mem_write_en}
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, branch_cond, mem_ready, halt_req;
  logic [6:0] opcode;
  logic ir_write_en, pc_write_en, pc_src, alu_src_sel, reg_write_en;
  logic mem_req, mem_read_en, mem_write_en, wb_sel, busy, error;
  logic [2:0] state;
  logic [CNT_W-1:0] retired_cnt, cycle_cnt, stall_cnt;
  logic [13:0] act;

  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .halt_req(halt_req), .ir_write_en(ir_write_en),
    .pc_write_en(pc_write_en), .pc_src(pc_src), .alu_src_sel(alu_src_sel),
    .reg_write_en(reg_write_en), .mem_req(mem_req), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .wb_sel(wb_sel), .state(state), .busy(busy),
    .error(error), .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign act = {state, ir_write_en, pc_write_en, pc_src, alu_src_sel, reg_write_en,
                mem_req, mem_read_en, mem_write_en, wb_sel, busy, error};

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_retired = '0, exp_cycles = '0, exp_stalls = '0;
  logic exp_err = 1'b0;
  logic [6:0] ops [5] = '{OP_R, OP_I, OP_L, OP_S, OP_B};
  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e = '0;
    e.st   = st;
    e.busy = (st != S_IDLE) && (st != S_HALT);
    e.err  = exp_err;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  // One clock: drive inputs after the falling edge, compare, then advance the model.
  task automatic cycle(input string name, input exp_t e, input logic [6:0] op, input logic rdy,
                       input logic bc, input logic hr, input logic st, input logic r);
    @(negedge clk);
    opcode = op; mem_ready = rdy; branch_cond = bc; halt_req = hr; start = st; rst = r;
    #1;
    check(name, 64'({act, retired_cnt}), 64'({e, exp_retired}));
    check({name, "_perf"}, {cycle_cnt, stall_cnt}, PERF ? {exp_cycles, exp_stalls} : 64'd0);
    if (e.pcw) exp_retired++;
    if (e.busy) exp_cycles++;
    if (e.st == S_MEM && !rdy) exp_stalls++;
  endtask

  task automatic clear_model();
    exp_retired = '0; exp_cycles = '0; exp_stalls = '0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0; opcode = '0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic idle_start();
    cycle("idle_start", mk(S_IDLE), junk(), rb(), rb(), rb(), 1'b1, 1'b0);
  endtask

  task automatic fetch_decode(input logic [6:0] op);
    exp_t e;
    e = mk(S_FETCH); e.ir = 1'b1;
    cycle("fetch", e, junk(), rb(), rb(), rb(), rb(), 1'b0);
    cycle("decode", mk(S_DECODE), op, rb(), rb(), rb(), rb(), 1'b0);
  endtask

  // Expected trace of one instruction from FETCH to its retiring cycle.
  task automatic run_instr(input logic [6:0] op, input int d, input logic bc, input logic hr);
    exp_t e;
    logic ls;
    ls = (op == OP_L) || (op == OP_S);
    fetch_decode(op);
    e = mk(S_EXEC); e.alu = (op == OP_I) || ls;
    if (op == OP_B) begin
      e.pcw = 1'b1; e.pcs = bc;
      cycle("exec_branch", e, junk(), rb(), bc, hr, rb(), 1'b0);
    end else begin
      cycle("exec", e, junk(), rb(), rb(), rb(), rb(), 1'b0);
    end
    if (ls) begin
      for (int i = 0; i <= d; i++) begin
        e = mk(S_MEM); e.mreq = 1'b1; e.mrd = (op == OP_L); e.mwr = (op == OP_S);
        if (i == d && op == OP_S) begin
          e.pcw = 1'b1;
          cycle("mem_store_done", e, junk(), 1'b1, rb(), hr, rb(), 1'b0);
        end else begin
          cycle("mem", e, junk(), (i == d), rb(), rb(), rb(), 1'b0);
        end
      end
    end
    if (op != OP_B && op != OP_S) begin
      e = mk(S_WB); e.rw = 1'b1; e.wbs = (op == OP_L); e.pcw = 1'b1;
      cycle("wb", e, junk(), rb(), rb(), hr, rb(), 1'b0);
    end
  endtask

  task automatic halt_cycles(input string name, input int n);
    for (int i = 0; i < n; i++)
      cycle(name, mk(S_HALT), junk(), rb(), rb(), rb(), 1'b1, 1'b0);
  endtask

  // Runs one table entry from FETCH until the DUT is back in FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0;
    int mcnt = 0;
    logic [5:0] seen = '0;
    do begin
      @(negedge clk);
      opcode = v.op; branch_cond = v.bc; halt_req = 1'b0; start = 1'b0;
      mem_ready = mem_req && (mcnt >= v.delay);
      #1;
      seen |= {alu_src_sel, wb_sel, pc_src, reg_write_en, mem_read_en, mem_write_en};
      if (mem_req) mcnt++;
      cyc++;
      @(posedge clk);
      #1;
    end while (state != S_FETCH && cyc < 20);
    exp_retired++;
    check($sformatf("vec%0d_latency", idx), 64'(cyc), 64'(v.lat));
    check($sformatf("vec%0d_mem_cycles", idx), 64'(mcnt), 64'(v.mem_cyc));
    check($sformatf("vec%0d_enables", idx), 64'(seen), 64'(v.seen));
    check($sformatf("vec%0d_retired", idx), 64'(retired_cnt), 64'(exp_retired));
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{OP_R, 0, 1'b0, 4, 0, 6'b000100};
    vecs[1] = '{OP_I, 0, 1'b1, 4, 0, 6'b100100};
    vecs[2] = '{OP_L, 3, 1'b0, 8, 4, 6'b110110};
    vecs[3] = '{OP_S, 0, 1'b0, 4, 1, 6'b100001};
    vecs[4] = '{OP_S, 2, 1'b1, 6, 3, 6'b100001};
    vecs[5] = '{OP_B, 0, 1'b1, 3, 0, 6'b001000};
    vecs[6] = '{OP_B, 0, 1'b0, 3, 0, 6'b000000};
    vecs[7] = '{OP_L, 0, 1'b0, 5, 1, 6'b110110};
    vecs[8] = '{OP_R, 0, 1'b1, 4, 0, 6'b000100};

    rst = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0; opcode = '0;

    // Reset state and IDLE ignoring everything except start.
    do_reset();
    cycle("reset_idle", mk(S_IDLE), junk(), rb(), rb(), rb(), 1'b0, 1'b0);
    cycle("idle_hold", mk(S_IDLE), junk(), rb(), rb(), 1'b1, 1'b0, 1'b0);
    idle_start();
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // halt_req in an R-type WB stops at the boundary; HALT ignores start.
    do_reset();
    idle_start();
    run_instr(OP_R, 0, 1'b0, 1'b1);
    halt_cycles("halt_after_wb", 3);

    // Illegal opcode: HALT with sticky error, no enables.
    do_reset();
    idle_start();
    fetch_decode(OP_BAD);
    exp_err = 1'b1;
    halt_cycles("illegal_halt", 4);

    // Store with mem_ready stuck low times out after MEM_TIMEOUT MEM cycles.
    do_reset();
    idle_start();
    fetch_decode(OP_S);
    e = mk(S_EXEC); e.alu = 1'b1;
    cycle("timeout_exec", e, junk(), rb(), rb(), rb(), rb(), 1'b0);
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      e = mk(S_MEM); e.mreq = 1'b1; e.mwr = 1'b1;
      cycle("timeout_mem", e, junk(), 1'b0, rb(), rb(), rb(), 1'b0);
    end
    exp_err = 1'b1;
    halt_cycles("timeout_halt", 3);

    // Reset in the store's ready cycle wins: no retire, back to IDLE.
    do_reset();
    idle_start();
    fetch_decode(OP_S);
    e = mk(S_EXEC); e.alu = 1'b1;
    cycle("rstmem_exec", e, junk(), rb(), rb(), rb(), rb(), 1'b0);
    e = mk(S_MEM); e.mreq = 1'b1; e.mwr = 1'b1;
    cycle("rstmem_wait", e, junk(), 1'b0, rb(), rb(), rb(), 1'b0);
    e.pcw = 1'b1;
    cycle("rstmem_assert", e, junk(), 1'b1, rb(), 1'b0, 1'b0, 1'b1);
    clear_model();
    cycle("rstmem_idle", mk(S_IDLE), junk(), rb(), rb(), rb(), 1'b0, 1'b0);
    cycle("rstmem_idle2", mk(S_IDLE), junk(), rb(), rb(), rb(), 1'b0, 1'b0);

    // Randomized instruction stream, halting on the last retire.
    do_reset();
    cycle("rand_reset_idle", mk(S_IDLE), junk(), rb(), rb(), rb(), 1'b0, 1'b0);
    idle_start();
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(4, 0)], int'($urandom_range(4, 0)), rb(), (n == 39));
    halt_cycles("rand_halt", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
